// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the MIPS pipeline registers.
//   DEF_DATA_W / DEF_REG_ADDR_W / DEF_ALUOP_W : default field widths
//   CTRL_*                                    : bit positions inside the
//                                               packed control bundle
//   ctrl_w()                                  : control bundle width
// Control bundle layout (LSB first):
//   [0] RegDst  [1] ALUSrc  [2] MemRead  [3] MemWrite  [4] MemtoReg
//   [5] RegWrite  [6 +: ALUOP_W] ALUOp
// The six flags sit at fixed positions, so the layout does not depend on
// ALUOP_W.
// ---------------------------------------------------------------------------
package pipe_pkg;

   localparam int DEF_DATA_W     = 32;
   localparam int DEF_REG_ADDR_W = 5;
   localparam int DEF_ALUOP_W    = 4;

   localparam int CTRL_FLAG_N    = 6;
   localparam int CTRL_REGDST    = 0;
   localparam int CTRL_ALUSRC    = 1;
   localparam int CTRL_MEMREAD   = 2;
   localparam int CTRL_MEMWRITE  = 3;
   localparam int CTRL_MEMTOREG  = 4;
   localparam int CTRL_REGWRITE  = 5;
   localparam int CTRL_ALUOP_LSB = 6;

   function automatic int ctrl_w(input int aluop_w);
      return CTRL_FLAG_N + aluop_w;
   endfunction

endpackage

// File: rtl/pipe_skid_slot.sv
// ---------------------------------------------------------------------------
// pipe_skid_slot
// One valid bit plus a payload register.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   load_i       : capture data_i and set valid
//   clear_i      : drop valid and zero the control field (top CTRL_W bits);
//                  has priority over load_i
//   data_i       : payload to capture
//   valid_o      : slot holds a live entry
//   data_o       : stored payload
// Clearing keeps the data field, only the control field is zeroed, so a
// dropped entry can never re-appear with live control bits.
// ---------------------------------------------------------------------------
module pipe_skid_slot #(
   parameter int W      = 8,
   parameter int CTRL_W = 1
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         load_i,
   input  logic         clear_i,
   input  logic [W-1:0] data_i,
   output logic         valid_o,
   output logic [W-1:0] data_o
);

   logic         valid_q, valid_d;
   logic [W-1:0] data_q,  data_d;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (clear_i) begin
         valid_d                  = 1'b0;
         data_d[W-1 -: CTRL_W]    = '0;
      end else if (load_i) begin
         valid_d = 1'b1;
         data_d  = data_i;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;

endmodule

// File: rtl/id_ex_pipe_stage.sv
// ---------------------------------------------------------------------------
// id_ex_pipe_stage
// ID/EX pipeline register with valid/ready handshake, 2-entry skid buffer
// and flush.
//   clk, rst                 : clock, asynchronous active-high reset
//   flush                    : kill main and skid entries, drop same-cycle input
//   in_valid / in_ready      : ID-side handshake
//   RegWrite..RegDst, ALUOp  : decode control inputs
//   PCplus4, ReadData1_in, ReadData2_in, SignExtendResult_in : data inputs
//   regAddress_in            : {rs, rt, rd}
//   out_valid / out_ready    : EX-side handshake
//   *Out / *_out, rsOut, rtOut, rdOut : registered fields of the main slot
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high (accept = in_valid & in_ready, fire = out_valid & out_ready).
// valid must not depend on ready; in_ready depends only on registered state
// (it is low exactly when the skid slot is occupied), so ID never sees a
// combinational path from out_ready.
// ---------------------------------------------------------------------------
module id_ex_pipe_stage
   import pipe_pkg::*;
#(
   parameter int DATA_W     = DEF_DATA_W,
   parameter int REG_ADDR_W = DEF_REG_ADDR_W,
   parameter int ALUOP_W    = DEF_ALUOP_W
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    flush,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic                    RegWrite,
   input  logic                    MemtoReg,
   input  logic                    MemWrite,
   input  logic                    MemRead,
   input  logic                    ALUSrc,
   input  logic                    RegDst,
   input  logic [ALUOP_W-1:0]      ALUOp,
   input  logic [DATA_W-1:0]       PCplus4,
   input  logic [DATA_W-1:0]       ReadData1_in,
   input  logic [DATA_W-1:0]       ReadData2_in,
   input  logic [DATA_W-1:0]       SignExtendResult_in,
   input  logic [3*REG_ADDR_W-1:0] regAddress_in,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    RegWriteOut,
   output logic                    MemtoRegOut,
   output logic                    MemWriteOut,
   output logic                    MemReadOut,
   output logic                    ALUSrcOut,
   output logic                    RegDstOut,
   output logic [ALUOP_W-1:0]      ALUOpOut,
   output logic [DATA_W-1:0]       PCplus4out,
   output logic [DATA_W-1:0]       ReadData1_out,
   output logic [DATA_W-1:0]       ReadData2_out,
   output logic [DATA_W-1:0]       SignExtendResult_out,
   output logic [REG_ADDR_W-1:0]   rsOut,
   output logic [REG_ADDR_W-1:0]   rtOut,
   output logic [REG_ADDR_W-1:0]   rdOut
);

   localparam int CTRL_W   = ctrl_w(ALUOP_W);
   localparam int OFF_ADDR = 0;
   localparam int OFF_IMM  = OFF_ADDR + 3*REG_ADDR_W;
   localparam int OFF_RD2  = OFF_IMM + DATA_W;
   localparam int OFF_RD1  = OFF_RD2 + DATA_W;
   localparam int OFF_PC   = OFF_RD1 + DATA_W;
   localparam int OFF_CTRL = OFF_PC + DATA_W;
   localparam int PAY_W    = OFF_CTRL + CTRL_W;

   logic [CTRL_W-1:0] in_ctrl, main_ctrl, out_ctrl;
   logic [PAY_W-1:0]  in_data, main_data, skid_data, main_src;
   logic              main_valid, skid_valid;
   logic              accept, fire, main_free;
   logic              main_load, main_clear, skid_load, skid_clear;

   always_comb begin
      in_ctrl                              = '0;
      in_ctrl[CTRL_REGDST]                 = RegDst;
      in_ctrl[CTRL_ALUSRC]                 = ALUSrc;
      in_ctrl[CTRL_MEMREAD]                = MemRead;
      in_ctrl[CTRL_MEMWRITE]               = MemWrite;
      in_ctrl[CTRL_MEMTOREG]               = MemtoReg;
      in_ctrl[CTRL_REGWRITE]               = RegWrite;
      in_ctrl[CTRL_ALUOP_LSB +: ALUOP_W]   = ALUOp;
   end

   assign in_data = {in_ctrl, PCplus4, ReadData1_in, ReadData2_in,
                     SignExtendResult_in, regAddress_in};

   assign in_ready  = ~skid_valid;
   assign accept    = in_valid & in_ready;
   assign fire      = main_valid & out_ready;
   // Main can take a new entry when it is empty or its entry leaves now.
   assign main_free = ~main_valid | fire;

   // Skid contents always go to main before any newer input.
   assign main_src   = skid_valid ? skid_data : in_data;
   assign main_load  = ~flush & main_free & (skid_valid | accept);
   assign main_clear = flush | (main_free & ~skid_valid & ~accept);
   // Skid only fills when main is stuck; in_ready is low whenever it is full.
   assign skid_load  = ~flush & main_valid & ~fire & accept;
   assign skid_clear = flush | main_free;

   pipe_skid_slot #(.W(PAY_W), .CTRL_W(CTRL_W)) u_main (
      .clk_i   (clk),
      .rst_i   (rst),
      .load_i  (main_load),
      .clear_i (main_clear),
      .data_i  (main_src),
      .valid_o (main_valid),
      .data_o  (main_data)
   );

   pipe_skid_slot #(.W(PAY_W), .CTRL_W(CTRL_W)) u_skid (
      .clk_i   (clk),
      .rst_i   (rst),
      .load_i  (skid_load),
      .clear_i (skid_clear),
      .data_i  (in_data),
      .valid_o (skid_valid),
      .data_o  (skid_data)
   );

   assign out_valid = main_valid;

   // Bubbles present all-zero control to EX; data fields are left visible.
   assign main_ctrl = main_data[OFF_CTRL +: CTRL_W];
   assign out_ctrl  = main_ctrl & {CTRL_W{main_valid}};

   assign RegDstOut   = out_ctrl[CTRL_REGDST];
   assign ALUSrcOut   = out_ctrl[CTRL_ALUSRC];
   assign MemReadOut  = out_ctrl[CTRL_MEMREAD];
   assign MemWriteOut = out_ctrl[CTRL_MEMWRITE];
   assign MemtoRegOut = out_ctrl[CTRL_MEMTOREG];
   assign RegWriteOut = out_ctrl[CTRL_REGWRITE];
   assign ALUOpOut    = out_ctrl[CTRL_ALUOP_LSB +: ALUOP_W];

   assign PCplus4out           = main_data[OFF_PC  +: DATA_W];
   assign ReadData1_out        = main_data[OFF_RD1 +: DATA_W];
   assign ReadData2_out        = main_data[OFF_RD2 +: DATA_W];
   assign SignExtendResult_out = main_data[OFF_IMM +: DATA_W];
   assign rsOut = main_data[OFF_ADDR + 2*REG_ADDR_W +: REG_ADDR_W];
   assign rtOut = main_data[OFF_ADDR + REG_ADDR_W   +: REG_ADDR_W];
   assign rdOut = main_data[OFF_ADDR                +: REG_ADDR_W];

endmodule

// File: tb/tb_id_ex_pipe_stage.sv
module tb_id_ex_pipe_stage;

   localparam int DATA_W     = 32;
   localparam int REG_ADDR_W = 5;
   localparam int ALUOP_W    = 4;
   localparam int VEC_W      = 6 + ALUOP_W + 4*DATA_W + 3*REG_ADDR_W;

   logic                    clk = 1'b0;
   logic                    rst = 1'b1;
   logic                    flush = 1'b0;
   logic                    in_valid = 1'b0;
   logic                    in_ready;
   logic                    RegWrite = 1'b0, MemtoReg = 1'b0, MemWrite = 1'b0;
   logic                    MemRead = 1'b0, ALUSrc = 1'b0, RegDst = 1'b0;
   logic [ALUOP_W-1:0]      ALUOp = '0;
   logic [DATA_W-1:0]       PCplus4 = '0, ReadData1_in = '0, ReadData2_in = '0;
   logic [DATA_W-1:0]       SignExtendResult_in = '0;
   logic [3*REG_ADDR_W-1:0] regAddress_in = '0;
   logic                    out_valid;
   logic                    out_ready = 1'b0;
   logic                    RegWriteOut, MemtoRegOut, MemWriteOut, MemReadOut;
   logic                    ALUSrcOut, RegDstOut;
   logic [ALUOP_W-1:0]      ALUOpOut;
   logic [DATA_W-1:0]       PCplus4out, ReadData1_out, ReadData2_out;
   logic [DATA_W-1:0]       SignExtendResult_out;
   logic [REG_ADDR_W-1:0]   rsOut, rtOut, rdOut;

   logic [VEC_W-1:0] exp_q[$];
   int n_checks = 0;
   int n_fail   = 0;

   id_ex_pipe_stage #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W), .ALUOP_W(ALUOP_W)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .RegWrite(RegWrite), .MemtoReg(MemtoReg), .MemWrite(MemWrite),
      .MemRead(MemRead), .ALUSrc(ALUSrc), .RegDst(RegDst), .ALUOp(ALUOp),
      .PCplus4(PCplus4), .ReadData1_in(ReadData1_in), .ReadData2_in(ReadData2_in),
      .SignExtendResult_in(SignExtendResult_in), .regAddress_in(regAddress_in),
      .out_valid(out_valid), .out_ready(out_ready),
      .RegWriteOut(RegWriteOut), .MemtoRegOut(MemtoRegOut), .MemWriteOut(MemWriteOut),
      .MemReadOut(MemReadOut), .ALUSrcOut(ALUSrcOut), .RegDstOut(RegDstOut),
      .ALUOpOut(ALUOpOut), .PCplus4out(PCplus4out), .ReadData1_out(ReadData1_out),
      .ReadData2_out(ReadData2_out), .SignExtendResult_out(SignExtendResult_out),
      .rsOut(rsOut), .rtOut(rtOut), .rdOut(rdOut)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   // ---------------- helpers ----------------
   function automatic logic [VEC_W-1:0] in_vec();
      return {RegWrite, MemtoReg, MemWrite, MemRead, ALUSrc, RegDst, ALUOp,
              PCplus4, ReadData1_in, ReadData2_in, SignExtendResult_in, regAddress_in};
   endfunction

   function automatic logic [VEC_W-1:0] out_vec();
      return {RegWriteOut, MemtoRegOut, MemWriteOut, MemReadOut, ALUSrcOut, RegDstOut,
              ALUOpOut, PCplus4out, ReadData1_out, ReadData2_out, SignExtendResult_out,
              rsOut, rtOut, rdOut};
   endfunction

   function automatic logic [5:0] out_flags();
      return {RegWriteOut, MemtoRegOut, MemWriteOut, MemReadOut, ALUSrcOut, RegDstOut};
   endfunction

   // ---------------- driver ----------------
   task automatic drive(input logic v, input logic [5:0] flags, input logic [ALUOP_W-1:0] aluop,
                        input logic [DATA_W-1:0] pc, input logic [DATA_W-1:0] rd1);
      in_valid = v;
      {RegWrite, MemtoReg, MemWrite, MemRead, ALUSrc, RegDst} = flags;
      ALUOp               = aluop;
      PCplus4             = pc;
      ReadData1_in        = rd1;
      ReadData2_in        = $urandom;
      SignExtendResult_in = $urandom;
      regAddress_in       = 15'($urandom_range(0, 32767));
   endtask

   // One clock: scoreboard at the falling edge (inputs stable), then advance
   // to just after the rising edge so callers can drive the next cycle.
   task automatic cycle();
      logic [VEC_W-1:0] exp_v;
      @(negedge clk);
      if (out_valid && out_ready) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL fire_unexpected: got %h, required no transfer", out_vec());
         end else begin
            exp_v = exp_q.pop_front();
            if (out_vec() !== exp_v) begin
               n_fail++;
               $display("FAIL fire_data: got %h, required %h", out_vec(), exp_v);
            end
         end
      end
      if (flush) exp_q.delete();
      else if (in_valid && in_ready) exp_q.push_back(in_vec());
      @(posedge clk);
      #1;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if (out_vec() !== '0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_state: outputs %h valid %b ready %b, required 0/0/1",
                  out_vec(), out_valid, in_ready);
      end
      rst = 1'b0;
      exp_q.delete();
   endtask

   task automatic test_stream();
      out_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         drive(1'b1, 6'b0, '0, DATA_W'(4*i), $urandom);
         cycle();
         n_checks++;
         if (out_valid !== 1'b1 || PCplus4out !== DATA_W'(4*i) || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL stream_beat%0d: valid %b pc %h ready %b, required 1 %h 1",
                     i, out_valid, PCplus4out, in_ready, 4*i);
         end
      end
      drive(1'b0, 6'b0, '0, '0, '0);
      cycle();
   endtask

   task automatic test_onehot_ctrl();
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, 6'(1 << i), '0, DATA_W'(32'h40 + 4*i), $urandom);
         cycle();
         n_checks++;
         if (out_flags() !== 6'(1 << i) || ALUOpOut !== '0) begin
            n_fail++;
            $display("FAIL onehot_bit%0d: flags %b aluop %h, required %b 0",
                     i, out_flags(), ALUOpOut, 6'(1 << i));
         end
      end
      drive(1'b1, 6'b0, 4'hA, 32'h60, $urandom);
      cycle();
      n_checks++;
      if (ALUOpOut !== 4'hA || out_flags() !== 6'b0) begin
         n_fail++;
         $display("FAIL aluop_a: aluop %h flags %b, required a 000000", ALUOpOut, out_flags());
      end
      drive(1'b0, 6'b0, '0, '0, '0);
      cycle();
   endtask

   task automatic test_stall_skid();
      out_ready = 1'b1;
      drive(1'b1, 6'b100001, 4'h3, 32'h100, 32'hA);   // A -> main
      cycle();
      out_ready = 1'b0;
      drive(1'b1, 6'b010010, 4'h5, 32'h104, 32'hB);   // B -> skid
      cycle();
      n_checks++;
      if (in_ready !== 1'b0 || PCplus4out !== 32'h100) begin
         n_fail++;
         $display("FAIL skid_fill: ready %b pc %h, required 0 100", in_ready, PCplus4out);
      end
      drive(1'b1, 6'b001100, 4'h7, 32'h108, 32'hC);   // C held off
      cycle();
      cycle();
      n_checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || PCplus4out !== 32'h100 || exp_q.size() != 2) begin
         n_fail++;
         $display("FAIL stall_hold: ready %b valid %b pc %h held %0d, required 0 1 100 2",
                  in_ready, out_valid, PCplus4out, exp_q.size());
      end
      out_ready = 1'b1;
      cycle();
      n_checks++;
      if (PCplus4out !== 32'h104 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL release_skid: pc %h ready %b, required 104 1", PCplus4out, in_ready);
      end
      cycle();
      n_checks++;
      if (PCplus4out !== 32'h108 || out_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL release_new: pc %h valid %b, required 108 1", PCplus4out, out_valid);
      end
      drive(1'b0, 6'b0, '0, '0, '0);
      cycle();
      n_checks++;
      if (out_valid !== 1'b0 || exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL stall_drain: valid %b left %0d, required 0 0", out_valid, exp_q.size());
      end
   endtask

   task automatic test_flush_full();
      out_ready = 1'b1;
      drive(1'b1, 6'b111111, 4'hF, 32'h200, 32'h11);
      cycle();
      out_ready = 1'b0;
      drive(1'b1, 6'b101010, 4'h9, 32'h204, 32'h22);
      cycle();
      drive(1'b0, 6'b0, '0, '0, '0);
      flush = 1'b1;
      cycle();
      flush = 1'b0;
      n_checks++;
      if (out_valid !== 1'b0 || out_flags() !== 6'b0 || ALUOpOut !== '0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL flush_full: valid %b flags %b aluop %h ready %b, required 0 0 0 1",
                  out_valid, out_flags(), ALUOpOut, in_ready);
      end
      out_ready = 1'b1;
      cycle();
      cycle();
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL flush_residue: valid %b ready %b, required 0 1", out_valid, in_ready);
      end
   endtask

   task automatic test_flush_accept();
      out_ready = 1'b1;
      drive(1'b1, 6'b100000, 4'h2, 32'h300, 32'h33);
      regAddress_in[4:0] = 5'd7;
      flush = 1'b1;
      cycle();
      flush = 1'b0;
      drive(1'b0, 6'b0, '0, '0, '0);
      n_checks++;
      if (out_valid !== 1'b0 || RegWriteOut !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_accept: valid %b regwrite %b, required 0 0", out_valid, RegWriteOut);
      end
      cycle();
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_accept_late: valid %b, required 0", out_valid);
      end
   endtask

   task automatic test_async_reset();
      out_ready = 1'b1;
      drive(1'b1, 6'b110000, 4'h1, 32'h500, 32'h55);
      cycle();
      drive(1'b1, 6'b000011, 4'h6, 32'h504, 32'h56);
      cycle();
      #2 rst = 1'b1;
      in_valid = 1'b0;
      #1;
      n_checks++;
      if (out_vec() !== '0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL async_reset: outputs %h valid %b ready %b, required 0/0/1",
                  out_vec(), out_valid, in_ready);
      end
      exp_q.delete();
      #2 rst = 1'b0;
      @(posedge clk);
      #1;
      drive(1'b1, 6'b010101, 4'hC, 32'h600, 32'h66);
      cycle();
      n_checks++;
      if (out_valid !== 1'b1 || PCplus4out !== 32'h600 || ReadData1_out !== 32'h66) begin
         n_fail++;
         $display("FAIL post_reset_capture: valid %b pc %h rd1 %h, required 1 600 66",
                  out_valid, PCplus4out, ReadData1_out);
      end
      drive(1'b0, 6'b0, '0, '0, '0);
   endtask

   task automatic test_drain();
      int budget;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      budget    = 20;
      while (exp_q.size() != 0 && budget > 0) begin
         cycle();
         budget--;
      end
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain_timeout: %0d entries outstanding, required 0", exp_q.size());
      end
   endtask

   // ---------------- sequence + report ----------------
   initial begin
      test_reset();
      test_stream();
      test_onehot_ctrl();
      test_stall_skid();
      test_flush_full();
      test_flush_accept();
      test_async_reset();
      test_drain();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
